// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin share of the SDRAM controller request port.
// An in-order tag FIFO routes each controller ack back to its requester.
module sdram_port_arbiter #(
    parameter int NUM_PORTS       = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [4*NUM_PORTS-1:0]   req_wr_i,
    input  logic [NUM_PORTS-1:0]     req_rd_i,
    input  logic [32*NUM_PORTS-1:0]  req_addr_i,
    input  logic [32*NUM_PORTS-1:0]  req_write_data_i,
    output logic [NUM_PORTS-1:0]     req_accept_o,
    output logic [NUM_PORTS-1:0]     req_ack_o,
    output logic [NUM_PORTS-1:0]     req_error_o,
    output logic [31:0]              req_read_data_o,
    output logic [3:0]               inport_wr_o,
    output logic                     inport_rd_o,
    output logic [31:0]              inport_addr_o,
    output logic [31:0]              inport_write_data_o,
    input  logic                     inport_accept_i,
    input  logic                     inport_ack_i,
    input  logic                     inport_error_i,
    input  logic [31:0]              inport_read_data_i,
    output logic                     spurious_ack_o
);

    localparam int PW = (NUM_PORTS > 2) ? 2 : 1;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state_q;
    logic [PW-1:0]  grant_q;
    logic [PW-1:0]  last_q;
    logic [PW-1:0]  tag_q [MAX_OUTSTANDING];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           spurious_q;

    logic [NUM_PORTS-1:0] port_req;
    logic [3:0]           wr_a    [NUM_PORTS];
    logic [31:0]          addr_a  [NUM_PORTS];
    logic [31:0]          wdata_a [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign wr_a[p]     = req_wr_i[4*p +: 4];
        assign addr_a[p]   = req_addr_i[32*p +: 32];
        assign wdata_a[p]  = req_write_data_i[32*p +: 32];
        assign port_req[p] = req_rd_i[p] | (|req_wr_i[4*p +: 4]);
    end

    logic          pick_vld;
    logic [PW-1:0] pick_idx;
    int            idx;

    // Search upward from the port after the last winner.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx = (int'(last_q) + i) % NUM_PORTS;
            if (!pick_vld && port_req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    logic                 in_grant;
    logic                 room;
    logic                 push;
    logic                 pop;
    logic [PW-1:0]        head;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic [NUM_PORTS-1:0] head_oh;

    assign in_grant = (state_q == GRANT);
    assign room     = (count_q < CW'(MAX_OUTSTANDING));
    assign push     = in_grant && inport_accept_i;
    assign pop      = inport_ack_i && (count_q != '0);
    assign head     = tag_q[rd_ptr_q];
    assign gnt_oh   = NUM_PORTS'(1) << grant_q;
    assign head_oh  = NUM_PORTS'(1) << head;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PW'(NUM_PORTS - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld && room) begin
                        grant_q <= pick_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (inport_accept_i) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end else if (!port_req[grant_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (inport_ack_i && (count_q == '0)) begin
                spurious_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q] <= grant_q;
        end
    end

    assign inport_rd_o         = in_grant & req_rd_i[grant_q];
    assign inport_wr_o         = in_grant ? wr_a[grant_q] : 4'h0;
    assign inport_addr_o       = in_grant ? addr_a[grant_q] : 32'h0;
    assign inport_write_data_o = in_grant ? wdata_a[grant_q] : 32'h0;

    assign req_accept_o    = push ? gnt_oh : '0;
    assign req_ack_o       = pop ? head_oh : '0;
    assign req_error_o     = (pop && inport_error_i) ? head_oh : '0;
    assign req_read_data_o = inport_read_data_i;
    assign spurious_ack_o  = spurious_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grants, fairness, FIFO limit,
// ack routing, push/pop overlap, spurious ack and mid-flight reset.
module tb_sdram_port_arbiter;

    localparam int NP = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*NP-1:0] req_wr;
    logic [NP-1:0]   req_rd;
    logic [32*NP-1:0] req_addr;
    logic [32*NP-1:0] req_wdata;
    logic [NP-1:0]   req_accept;
    logic [NP-1:0]   req_ack;
    logic [NP-1:0]   req_error;
    logic [31:0]     req_rdata;
    logic [3:0]      in_wr;
    logic            in_rd;
    logic [31:0]     in_addr;
    logic [31:0]     in_wdata;
    logic            in_accept;
    logic            in_ack;
    logic            in_error;
    logic [31:0]     in_rdata;
    logic            spurious;

    sdram_port_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(4)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_wr_i            (req_wr),
        .req_rd_i            (req_rd),
        .req_addr_i          (req_addr),
        .req_write_data_i    (req_wdata),
        .req_accept_o        (req_accept),
        .req_ack_o           (req_ack),
        .req_error_o         (req_error),
        .req_read_data_o     (req_rdata),
        .inport_wr_o         (in_wr),
        .inport_rd_o         (in_rd),
        .inport_addr_o       (in_addr),
        .inport_write_data_o (in_wdata),
        .inport_accept_i     (in_accept),
        .inport_ack_i        (in_ack),
        .inport_error_i      (in_error),
        .inport_read_data_i  (in_rdata),
        .spurious_ack_o      (spurious)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int nchk = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        req_wr    = '0;
        req_rd    = '0;
        req_wdata = '0;
        in_accept = 1'b0;
        in_ack    = 1'b0;
        in_error  = 1'b0;
        in_rdata  = '0;
        for (int p = 0; p < NP; p++) req_addr[32*p +: 32] = 32'h100 * (p + 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input int p);
        req_rd    = NP'(1) << p;
        in_accept = 1'b1;
        tick();
        #1;
        check("issue_acc", 32'(req_accept), 32'(NP'(1) << p));
        check("issue_addr", in_addr, 32'h100 * (p + 1));
        tick();
        req_rd    = '0;
        in_accept = 1'b0;
    endtask

    task automatic give_ack(input logic err, input logic [31:0] d,
                            input logic [NP-1:0] port_oh);
        in_ack   = 1'b1;
        in_error = err;
        in_rdata = d;
        #1;
        check("ack_port", 32'(req_ack), 32'(port_oh));
        check("ack_err", 32'(req_error), err ? 32'(port_oh) : 32'h0);
        check("ack_data", req_rdata, d);
        tick();
        in_ack   = 1'b0;
        in_error = 1'b0;
    endtask

    logic [2:0] fa_acc [12] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                                3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
    logic [2:0] fa_ack [12] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
                                3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    logic       ff_rd  [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst = 1'b1;
        clr();
        do_reset();
        #1;
        check("rst_acc", 32'(req_accept), 32'h0);
        check("rst_ack", 32'(req_ack), 32'h0);
        check("rst_rd", 32'(in_rd), 32'h0);
        check("rst_addr", in_addr, 32'h0);
        check("rst_spur", 32'(spurious), 32'h0);

        // single port read
        req_rd = 3'b010;
        req_addr[63:32] = 32'h0000_1000;
        tick(); #1;
        check("sp_rd", 32'(in_rd), 32'h1);
        check("sp_addr", in_addr, 32'h0000_1000);
        check("sp_acc0", 32'(req_accept), 32'h0);
        tick(); #1;
        check("sp_rd2", 32'(in_rd), 32'h1);
        check("sp_acc1", 32'(req_accept), 32'h0);
        tick();
        in_accept = 1'b1;
        #1;
        check("sp_acc", 32'(req_accept), 32'h2);
        tick();
        req_rd = '0;
        in_accept = 1'b0;
        #1;
        check("sp_idle", 32'(in_rd), 32'h0);
        check("sp_acc2", 32'(req_accept), 32'h0);
        repeat (3) tick();
        give_ack(1'b0, 32'hDEAD_BEEF, 3'b010);
        #1;
        check("sp_ack_once", 32'(req_ack), 32'h0);
        check("sp_spur", 32'(spurious), 32'h0);

        // fairness: all ports requesting, instant accept, ack after each
        do_reset();
        req_rd = 3'b111;
        in_accept = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            in_ack = (i > 0) && (fa_acc[i-1] != 3'b000);
            #1;
            check($sformatf("fair_acc%0d", i), 32'(req_accept), 32'(fa_acc[i]));
            check($sformatf("fair_ack%0d", i), 32'(req_ack), 32'(fa_ack[i]));
        end

        // FIFO full: fifth request waits for an ack
        do_reset();
        req_rd = 3'b001;
        in_accept = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            in_ack = (i == 9);
            #1;
            check($sformatf("full_rd%0d", i), 32'(in_rd), 32'(ff_rd[i]));
            check($sformatf("full_ack%0d", i), 32'(req_ack), (i == 9) ? 32'h1 : 32'h0);
        end

        // ack routing with error on second ack
        do_reset();
        issue(2);
        issue(0);
        issue(2);
        give_ack(1'b0, 32'h1111_0000, 3'b100);
        give_ack(1'b1, 32'h2222_0000, 3'b001);
        give_ack(1'b0, 32'h3333_0000, 3'b100);

        // simultaneous push and pop, then spurious ack
        do_reset();
        issue(1);
        req_rd = 3'b001;
        in_accept = 1'b1;
        tick();
        in_ack = 1'b1;
        #1;
        check("pp_acc", 32'(req_accept), 32'h1);
        check("pp_ack_head", 32'(req_ack), 32'h2);
        tick();
        req_rd = '0;
        in_accept = 1'b0;
        #1;
        check("pp_ack_new", 32'(req_ack), 32'h1);
        check("pp_spur0", 32'(spurious), 32'h0);
        tick(); #1;
        check("spur_noack", 32'(req_ack), 32'h0);
        tick();
        in_ack = 1'b0;
        #1;
        check("spur_set", 32'(spurious), 32'h1);
        tick(); #1;
        check("spur_sticky", 32'(spurious), 32'h1);

        // reset in GRANT with two tags outstanding
        issue(0);
        issue(1);
        req_rd = 3'b100;
        tick(); #1;
        check("rg_rd", 32'(in_rd), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_rd = 3'b110;
        req_wr[3:0] = 4'hF;
        req_wdata[31:0] = 32'hCAFE_F00D;
        #1;
        check("rg_rd0", 32'(in_rd), 32'h0);
        check("rg_wr0", 32'(in_wr), 32'h0);
        check("rg_addr0", in_addr, 32'h0);
        check("rg_wd0", in_wdata, 32'h0);
        check("rg_acc0", 32'(req_accept), 32'h0);
        check("rg_spur0", 32'(spurious), 32'h0);
        in_ack = 1'b1;
        #1;
        check("rg_empty", 32'(req_ack), 32'h0);
        tick();
        in_ack = 1'b0;
        in_accept = 1'b1;
        #1;
        check("rg_wr", 32'(in_wr), 32'hF);
        check("rg_wd", in_wdata, 32'hCAFE_F00D);
        check("rg_rdq", 32'(in_rd), 32'h0);
        check("rg_acc", 32'(req_accept), 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
